// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   Input channel : in_valid, in_ready, a, b, cin
//   Output channel: out_valid, out_ready, sum, cout, ovf
//   master modport: operand source / result consumer side.
//   slave modport : the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder, {cout,sum} = a + b + cin.
//   One CHUNK = WIDTH/STAGES bit slice is added per stage; the carry ripples
//   through the stage registers. Latency is STAGES cycles counting the
//   accepting edge; throughput is one operation per cycle. A full-pipe stall
//   (out_valid & !out_ready) freezes every stage.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears valids, gates outputs)
//   bus    - pipe_adder_if.slave: in_valid/in_ready/a/b/cin in,
//            out_valid/out_ready/sum/cout/ovf out
// Build option:
//   PIPE_ADD_OVF_EN - when defined, ovf reports signed overflow of the
//   presented result; otherwise ovf is tied to 0.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // control
  logic [STAGES-1:0] vld_p;
  logic [STAGES:0]   vld_shift;
  logic              ready_q;
  logic              advance;
  logic              out_valid;
  logic              push;

  // stage registers: full-width operand copies, partial sum, carry
  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [WIDTH-1:0] s_p [STAGES];
  logic             c_p [STAGES];

  // per-stage inputs and next values
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];
  logic             c_nx  [STAGES];
  logic [CHUNK:0]   part;

  assign out_valid    = vld_p[STAGES-1];
  assign advance      = !out_valid || bus.out_ready;
  // ready_q delays in_ready until the first edge after reset release
  assign bus.in_ready = ready_q && advance;
  assign push         = bus.in_valid && bus.in_ready;
  assign vld_shift    = {vld_p, push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      vld_p   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (advance) vld_p <= vld_shift[STAGES-1:0];
    end
  end

  // stage k adds slice k of the operands it received
  always_comb begin
    part     = '0;
    a_src[0] = bus.a;
    b_src[0] = bus.b;
    s_src[0] = '0;
    c_src[0] = bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_p[k-1];
      b_src[k] = b_p[k-1];
      s_src[k] = s_p[k-1];
      c_src[k] = c_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part    = add_chunk(a_src[k][k*CHUNK +: CHUNK],
                          b_src[k][k*CHUNK +: CHUNK], c_src[k]);
      s_nx[k] = s_src[k];
      s_nx[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_nx[k] = part[CHUNK];
    end
  end

  // stage boundary: every stage loads together or all hold
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= a_src[k];
        b_p[k] <= b_src[k];
        s_p[k] <= s_nx[k];
        c_p[k] <= c_nx[k];
      end
    end
  end

  // outputs are forced to 0 whenever no valid result is presented
  assign bus.out_valid = out_valid;
  assign bus.sum       = out_valid ? s_p[STAGES-1] : '0;
  assign bus.cout      = out_valid && c_p[STAGES-1];

`ifdef PIPE_ADD_OVF_EN
  // operand sign bits ride along in the last stage's operand copies
  logic sgn_a, sgn_b, sgn_s;
  assign sgn_a   = a_p[STAGES-1][WIDTH-1];
  assign sgn_b   = b_p[STAGES-1][WIDTH-1];
  assign sgn_s   = s_p[STAGES-1][WIDTH-1];
  assign bus.ovf = out_valid && (sgn_a == sgn_b) && (sgn_s != sgn_a);
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
`ifdef PIPE_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(16)) bus  ();
  pipe_adder_if #(.WIDTH(1))  bus1 ();

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_adder #(.WIDTH(1),  .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b1;
  endtask

  // drive one operation into the 16-bit pipe and count edges until out_valid
  task automatic launch_one(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int bad;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_cout_ovf got=%b%b want=00", bus.cout, bus.ovf); end
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_w1_out_valid got=%b want=0", bus1.out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_pre_edge got=%b want=0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready_post_edge got=%b want=1", bus.in_ready); end
    // unknown operands while idle must never create a valid result
    bus.a = 'x;
    bus.b = 'x;
    bus.cin = 1'bx;
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_x_out_valid got=%0d want=0 valid cycles", bad); end
    idle_inputs();
  endtask

  task automatic test_fa_exhaustive();
    logic [7:0] sum_t;
    logic [7:0] cout_t;
    logic [2:0] v;
    sum_t  = 8'b1001_0110;
    cout_t = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.a   = v[2];
      bus1.b   = v[1];
      bus1.cin = v[0];
      @(posedge clk);
      #1;
      checks++; if (bus1.out_valid !== 1'b1) begin failures++; $display("FAIL fa_valid[%0d] got=%b want=1", i, bus1.out_valid); end
      checks++; if (bus1.sum !== sum_t[i]) begin failures++; $display("FAIL fa_sum[%0d] got=%b want=%b", i, bus1.sum, sum_t[i]); end
      checks++; if (bus1.cout !== cout_t[i]) begin failures++; $display("FAIL fa_cout[%0d] got=%b want=%b", i, bus1.cout, cout_t[i]); end
    end
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL fa_drain got=%b want=0", bus1.out_valid); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    launch_one(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL ripple_latency got=%0d want=3 edges after accept", lat); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b want=1", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ripple_ovf got=%b want=0", bus.ovf); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000) begin failures++; $display("FAIL ripple_drain got=%b/%h want=0/0000", bus.out_valid, bus.sum); end
  endtask

  task automatic test_ovf();
    int lat;
    launch_one(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (bus.sum !== 16'h8000) begin failures++; $display("FAIL ovf_pos_sum got=%h want=8000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL ovf_pos_cout got=%b want=0", bus.cout); end
    checks++; if (bus.ovf !== OVF_ON) begin failures++; $display("FAIL ovf_pos_ovf got=%b want=%b", bus.ovf, OVF_ON); end
    launch_one(16'h8000, 16'h8000, 1'b0, lat);
    checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin failures++; $display("FAIL ovf_neg_result got=%b/%h want=1/0000", bus.cout, bus.sum); end
    checks++; if (bus.ovf !== OVF_ON) begin failures++; $display("FAIL ovf_neg_ovf got=%b want=%b", bus.ovf, OVF_ON); end
    launch_one(16'h1234, 16'h4321, 1'b1, lat);
    checks++; if (bus.sum !== 16'h5556 || bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_none got=%h/%b want=5556/0", bus.sum, bus.ovf); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] exp;
    int sent, got, cyc, gaps;
    sent = 0; got = 0; cyc = 0; gaps = 0;
    bus.out_ready = 1'b1;
    while (got < 100 && cyc < 400) begin
      @(negedge clk);
      if (got > 0 && !bus.out_valid) gaps++;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b2b_unexpected got=%h want=no result", bus.sum);
        end else begin
          exp = q.pop_front();
          checks++; if ({bus.cout, bus.sum} !== exp) begin failures++; $display("FAIL b2b_result[%0d] got=%h want=%h", got, {bus.cout, bus.sum}, exp); end
        end
        got++;
      end
      if (sent < 100) begin
        bus.in_valid = 1'b1;
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, bus.a} + {1'b0, bus.b} + 17'(bus.cin));
        sent++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 100) begin failures++; $display("FAIL b2b_count got=%0d want=100", got); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d want=0", q.size()); end
  endtask

  task automatic test_backpressure();
    logic [16:0] q[$];
    logic [16:0] exp;
    logic [16:0] held;
    logic [15:0] cur_a, cur_b;
    logic        cur_c, stall, have_op;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; have_op = 1'b0;
    held = '0; cur_a = '0; cur_b = '0; cur_c = 1'b0;
    while (got < 20 && cyc < 200) begin
      @(negedge clk);
      stall = (cyc >= 8 && cyc < 14);
      bus.out_ready = !stall;
      #1;
      if (stall) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b want=0", cyc, bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b want=1", cyc, bus.out_valid); end
        if (cyc == 8) held = {bus.cout, bus.sum};
        else begin
          checks++; if ({bus.cout, bus.sum} !== held) begin failures++; $display("FAIL bp_hold[%0d] got=%h want=%h", cyc, {bus.cout, bus.sum}, held); end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bp_unexpected got=%h want=no result", bus.sum);
        end else begin
          exp = q.pop_front();
          checks++; if ({bus.cout, bus.sum} !== exp) begin failures++; $display("FAIL bp_result[%0d] got=%h want=%h", got, {bus.cout, bus.sum}, exp); end
        end
        got++;
      end
      if (sent < 20) begin
        if (!have_op) begin
          cur_a = 16'($urandom);
          cur_b = 16'($urandom);
          cur_c = 1'($urandom);
          have_op = 1'b1;
        end
        bus.in_valid = 1'b1;
        bus.a = cur_a;
        bus.b = cur_b;
        bus.cin = cur_c;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, cur_a} + {1'b0, cur_b} + 17'(cur_c));
        sent++;
        have_op = 1'b0;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 20) begin failures++; $display("FAIL bp_count got=%0d want=20", got); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d want=0", q.size()); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int stale, lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'h1111 * 16'(i + 1);
      bus.b = 16'h0101;
      bus.cin = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b want=1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000 || bus.cout !== 1'b0) begin failures++; $display("FAIL mid_sum got=%b/%h want=0/0000", bus.cout, bus.sum); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b want=0", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale got=%0d want=0 valid cycles", stale); end
    launch_one(16'hA5A5, 16'h5A5A, 1'b1, lat);
    checks++; if (lat != 3 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin failures++; $display("FAIL mid_after got=lat%0d %b/%h want=lat3 1/0000", lat, bus.cout, bus.sum); end
  endtask

  initial begin
    test_reset();
    test_fa_exhaustive();
    test_carry_ripple();
    test_ovf();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
